// File: rtl/pcie_dllp_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_dllp_rx_checker
//  Purpose  : Receive-side DLLP checker. Takes a byte-serial stream of 6-byte
//             DLLPs (4 content bytes + 2 CRC bytes), recomputes the 16-bit
//             DLLP CRC, and decodes good DLLPs into Ack/Nak and flow-control
//             events. Keeps saturating good/bad statistics counters.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i         clock, rising edge
//    rst_i         synchronous active-low reset
//    dllp_data_i   DLLP byte
//    dllp_valid_i  byte valid (low = stall)
//    dllp_sop_i    marks byte 0 of a DLLP (with valid)
//    dllp_done_o   pulse: DLLP finished checking
//    crc_err_o     pulse with done: CRC mismatch
//    malformed_o   pulse: truncated DLLP or stray byte while idle
//    dllp_type_o   byte 0 of last completed DLLP
//    dllp_body_o   bytes 1..3 of last completed DLLP (byte 1 in [23:16])
//    ack_o/nak_o   pulses: good Ack / Nak
//    seq_num_o     sequence number for Ack/Nak
//    fc_valid_o    pulse: good InitFC1/InitFC2/UpdateFC
//    fc_kind_o     0 InitFC1, 1 InitFC2, 2 UpdateFC
//    fc_class_o    0 P, 1 NP, 2 Cpl
//    fc_vc_o       virtual channel
//    hdr_fc_o      header credits
//    data_fc_o     data credits
//    good_cnt_o    saturating good-DLLP count
//    err_cnt_o     saturating CRC-error count
// ============================================================================
module pcie_dllp_rx_checker #(
    parameter int          CNT_W    = 16,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       dllp_data_i,
    input  logic             dllp_valid_i,
    input  logic             dllp_sop_i,
    output logic             dllp_done_o,
    output logic             crc_err_o,
    output logic             malformed_o,
    output logic [7:0]       dllp_type_o,
    output logic [23:0]      dllp_body_o,
    output logic             ack_o,
    output logic             nak_o,
    output logic [11:0]      seq_num_o,
    output logic             fc_valid_o,
    output logic [1:0]       fc_kind_o,
    output logic [1:0]       fc_class_o,
    output logic [2:0]       fc_vc_o,
    output logic [7:0]       hdr_fc_o,
    output logic [11:0]      data_fc_o,
    output logic [CNT_W-1:0] good_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BODY   = 2'd1;
    localparam logic [1:0] S_CRC_LO = 2'd2;
    localparam logic [1:0] S_CRC_HI = 2'd3;

    localparam logic [15:0] c_poly = 16'hD008;

    // One byte of the LSB-first reflected CRC-16 (poly 100Bh); shared with
    // the transmit-side generator.
    function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                             input logic [7:0]  b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_poly) : (c >> 1);
        end
        return c;
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       r_idx;
    logic [15:0]      r_crc;
    logic [7:0]       r_b0, r_b1, r_b2, r_b3;
    logic [7:0]       r_crc_lo;

    logic             r_done, r_crc_err, r_malformed;
    logic             r_ack, r_nak, r_fc_valid;
    logic [7:0]       r_type;
    logic [23:0]      r_body;
    logic [11:0]      r_seq;
    logic [1:0]       r_fc_kind, r_fc_class;
    logic [2:0]       r_fc_vc;
    logic [7:0]       r_hdr_fc;
    logic [11:0]      r_data_fc;
    logic [CNT_W-1:0] r_good_cnt, r_err_cnt;

    logic             w_start;
    logic [15:0]      w_crc_base;
    logic [15:0]      w_crc_next;
    logic             w_crc_bad;
    logic             w_is_ack, w_is_nak, w_fc_hit;
    logic [1:0]       w_fc_kind;

    // A sop always restarts the CRC from the seed, whatever state we are in.
    assign w_start    = dllp_valid_i & dllp_sop_i;
    assign w_crc_base = w_start ? CRC_INIT : r_crc;
    assign w_crc_next = crc_step(w_crc_base, dllp_data_i);

    // Evaluated while the final CRC byte is on the input.
    assign w_crc_bad  = ({dllp_data_i, r_crc_lo} != ~r_crc);

    // Type decode. For FC types the low two bits of the upper nibble give the
    // class directly (x4/xC/x8 = P, x5/xD/x9 = NP, x6/xE/xA = Cpl).
    always_comb begin
        w_is_ack  = (r_b0 == 8'h00);
        w_is_nak  = (r_b0 == 8'h10);
        w_fc_hit  = 1'b0;
        w_fc_kind = 2'd0;
        case (r_b0[7:4])
            4'h4, 4'h5, 4'h6: begin w_fc_hit = ~r_b0[3]; w_fc_kind = 2'd0; end
            4'hC, 4'hD, 4'hE: begin w_fc_hit = ~r_b0[3]; w_fc_kind = 2'd1; end
            4'h8, 4'h9, 4'hA: begin w_fc_hit = ~r_b0[3]; w_fc_kind = 2'd2; end
            default:          begin w_fc_hit = 1'b0;     w_fc_kind = 2'd0; end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_crc       <= CRC_INIT;
            r_b0        <= 8'h00;
            r_b1        <= 8'h00;
            r_b2        <= 8'h00;
            r_b3        <= 8'h00;
            r_crc_lo    <= 8'h00;
            r_done      <= 1'b0;
            r_crc_err   <= 1'b0;
            r_malformed <= 1'b0;
            r_ack       <= 1'b0;
            r_nak       <= 1'b0;
            r_fc_valid  <= 1'b0;
            r_type      <= 8'h00;
            r_body      <= 24'h0;
            r_seq       <= 12'h0;
            r_fc_kind   <= 2'd0;
            r_fc_class  <= 2'd0;
            r_fc_vc     <= 3'd0;
            r_hdr_fc    <= 8'h00;
            r_data_fc   <= 12'h0;
            r_good_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_crc_err   <= 1'b0;
            r_malformed <= 1'b0;
            r_ack       <= 1'b0;
            r_nak       <= 1'b0;
            r_fc_valid  <= 1'b0;

            if (dllp_valid_i) begin
                if (dllp_sop_i) begin
                    // A sop mid-DLLP abandons it silently apart from malformed.
                    if (r_state != S_IDLE) begin
                        r_malformed <= 1'b1;
                    end
                    r_b0    <= dllp_data_i;
                    r_crc   <= w_crc_next;
                    r_idx   <= 2'd1;
                    r_state <= S_BODY;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_malformed <= 1'b1;
                        end
                        S_BODY: begin
                            case (r_idx)
                                2'd1:    r_b1 <= dllp_data_i;
                                2'd2:    r_b2 <= dllp_data_i;
                                default: r_b3 <= dllp_data_i;
                            endcase
                            r_crc <= w_crc_next;
                            r_idx <= r_idx + 2'd1;
                            if (r_idx == 2'd3) begin
                                r_state <= S_CRC_LO;
                            end
                        end
                        S_CRC_LO: begin
                            r_crc_lo <= dllp_data_i;
                            r_state  <= S_CRC_HI;
                        end
                        default: begin
                            // Last byte: publish results in the next cycle.
                            r_done     <= 1'b1;
                            r_crc_err  <= w_crc_bad;
                            r_ack      <= ~w_crc_bad & w_is_ack;
                            r_nak      <= ~w_crc_bad & w_is_nak;
                            r_fc_valid <= ~w_crc_bad & w_fc_hit;
                            r_type     <= r_b0;
                            r_body     <= {r_b1, r_b2, r_b3};
                            r_seq      <= {r_b2[3:0], r_b3};
                            r_fc_kind  <= w_fc_kind;
                            r_fc_class <= r_b0[5:4];
                            r_fc_vc    <= r_b0[2:0];
                            r_hdr_fc   <= {r_b1[5:0], r_b2[7:6]};
                            r_data_fc  <= {r_b2[3:0], r_b3};
                            if (w_crc_bad) begin
                                if (r_err_cnt != '1) begin
                                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                                end
                            end else begin
                                if (r_good_cnt != '1) begin
                                    r_good_cnt <= r_good_cnt + CNT_W'(1);
                                end
                            end
                            r_crc   <= CRC_INIT;
                            r_idx   <= 2'd0;
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign dllp_done_o = r_done;
    assign crc_err_o   = r_crc_err;
    assign malformed_o = r_malformed;
    assign dllp_type_o = r_type;
    assign dllp_body_o = r_body;
    assign ack_o       = r_ack;
    assign nak_o       = r_nak;
    assign seq_num_o   = r_seq;
    assign fc_valid_o  = r_fc_valid;
    assign fc_kind_o   = r_fc_kind;
    assign fc_class_o  = r_fc_class;
    assign fc_vc_o     = r_fc_vc;
    assign hdr_fc_o    = r_hdr_fc;
    assign data_fc_o   = r_data_fc;
    assign good_cnt_o  = r_good_cnt;
    assign err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcie_dllp_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcie_dllp_rx_checker
//  Purpose  : Scoreboard bench for pcie_dllp_rx_checker. Stimulus pushes the
//             expected completion record; a monitor pops and compares it on
//             every dllp_done_o pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcie_dllp_rx_checker;

    localparam int CNT_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [7:0]       dllp_data_i;
    logic             dllp_valid_i;
    logic             dllp_sop_i;
    logic             dllp_done_o;
    logic             crc_err_o;
    logic             malformed_o;
    logic [7:0]       dllp_type_o;
    logic [23:0]      dllp_body_o;
    logic             ack_o;
    logic             nak_o;
    logic [11:0]      seq_num_o;
    logic             fc_valid_o;
    logic [1:0]       fc_kind_o;
    logic [1:0]       fc_class_o;
    logic [2:0]       fc_vc_o;
    logic [7:0]       hdr_fc_o;
    logic [11:0]      data_fc_o;
    logic [CNT_W-1:0] good_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    always #5 clk_i = ~clk_i;

    pcie_dllp_rx_checker #(.CNT_W(CNT_W), .CRC_INIT(16'hFFFF)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dllp_data_i  (dllp_data_i),
        .dllp_valid_i (dllp_valid_i),
        .dllp_sop_i   (dllp_sop_i),
        .dllp_done_o  (dllp_done_o),
        .crc_err_o    (crc_err_o),
        .malformed_o  (malformed_o),
        .dllp_type_o  (dllp_type_o),
        .dllp_body_o  (dllp_body_o),
        .ack_o        (ack_o),
        .nak_o        (nak_o),
        .seq_num_o    (seq_num_o),
        .fc_valid_o   (fc_valid_o),
        .fc_kind_o    (fc_kind_o),
        .fc_class_o   (fc_class_o),
        .fc_vc_o      (fc_vc_o),
        .hdr_fc_o     (hdr_fc_o),
        .data_fc_o    (data_fc_o),
        .good_cnt_o   (good_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    typedef struct {
        logic        ack;
        logic        nak;
        logic        fcv;
        logic [1:0]  kind;
        logic [1:0]  cls;
        logic [2:0]  vc;
        logic [7:0]  hdr;
        logic [11:0] dat;
        logic [11:0] seq;
        logic [7:0]  typ;
        logic [23:0] body;
        logic        err;
        logic [1:0]  gcnt;
        logic [1:0]  ecnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   mal_cnt = 0;
    int   cyc = 0;
    int   done_cyc[$];
    int   mdl_good = 0;
    int   mdl_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic ack, input logic nak, input logic fcv,
                                input logic [1:0] kind, input logic [1:0] cls,
                                input logic [2:0] vc, input logic [7:0] hdr,
                                input logic [11:0] dat, input logic [11:0] seq);
        exp_t e;
        e.ack = ack; e.nak = nak; e.fcv = fcv; e.kind = kind; e.cls = cls;
        e.vc = vc; e.hdr = hdr; e.dat = dat; e.seq = seq;
        e.typ = 8'h00; e.body = 24'h0; e.err = 1'b0; e.gcnt = 2'd0; e.ecnt = 2'd0;
        return e;
    endfunction

    // Bit-serial form of the reflected CRC-16: the 32 content bits enter
    // LSB of byte 0 first. Returns the value that goes on the wire.
    function automatic logic [15:0] bench_crc(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        logic [15:0] c;
        logic [31:0] s;
        logic        fb;
        c = 16'hFFFF;
        s = {b3, b2, b1, b0};
        for (int i = 0; i < 32; i++) begin
            fb = c[0] ^ s[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hD008;
        end
        return ~c;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            if (malformed_o) mal_cnt++;
            if (dllp_done_o) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done with type %0h, expected none", dllp_type_o);
                end else begin
                    mon_e = sb.pop_front();
                    check("type",     dllp_type_o, mon_e.typ);
                    check("body",     dllp_body_o, mon_e.body);
                    check("crc_err",  crc_err_o,   mon_e.err);
                    check("ack",      ack_o,       mon_e.ack);
                    check("nak",      nak_o,       mon_e.nak);
                    check("fc_valid", fc_valid_o,  mon_e.fcv);
                    check("good_cnt", good_cnt_o,  mon_e.gcnt);
                    check("err_cnt",  err_cnt_o,   mon_e.ecnt);
                    if (mon_e.ack || mon_e.nak) check("seq_num", seq_num_o, mon_e.seq);
                    if (mon_e.fcv) begin
                        check("fc_kind",  fc_kind_o,  mon_e.kind);
                        check("fc_class", fc_class_o, mon_e.cls);
                        check("fc_vc",    fc_vc_o,    mon_e.vc);
                        check("hdr_fc",   hdr_fc_o,   mon_e.hdr);
                        check("data_fc",  data_fc_o,  mon_e.dat);
                    end
                end
            end else begin
                check("stray_pulse", {crc_err_o, ack_o, nak_o, fc_valid_o}, 4'b0000);
            end
        end
    end

    task automatic drive(input logic [7:0] d, input logic s);
        dllp_data_i  = d;
        dllp_sop_i   = s;
        dllp_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        dllp_valid_i = 1'b0;
        dllp_sop_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic gap(input int maxgap);
        if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
    endtask

    task automatic send_dllp(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input bit corrupt, input int maxgap, input exp_t e);
        logic [15:0] crc;
        crc = bench_crc(b0, b1, b2, b3);
        if (corrupt) crc[0] = ~crc[0];
        e.typ  = b0;
        e.body = {b1, b2, b3};
        e.err  = corrupt;
        if (corrupt) begin
            e.ack = 1'b0; e.nak = 1'b0; e.fcv = 1'b0;
            if (mdl_err < 3) mdl_err++;
        end else begin
            if (mdl_good < 3) mdl_good++;
        end
        e.gcnt = 2'(mdl_good);
        e.ecnt = 2'(mdl_err);
        sb.push_back(e);
        drive(b0, 1'b1);        gap(maxgap);
        drive(b1, 1'b0);        gap(maxgap);
        drive(b2, 1'b0);        gap(maxgap);
        drive(b3, 1'b0);        gap(maxgap);
        drive(crc[7:0], 1'b0);  gap(maxgap);
        drive(crc[15:8], 1'b0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        idle(2);
        check(name, sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},  dllp_done_o, 0);
        check({tag, "_err"},   crc_err_o,   0);
        check({tag, "_mal"},   malformed_o, 0);
        check({tag, "_type"},  dllp_type_o, 0);
        check({tag, "_body"},  dllp_body_o, 0);
        check({tag, "_ack"},   ack_o,       0);
        check({tag, "_nak"},   nak_o,       0);
        check({tag, "_seq"},   seq_num_o,   0);
        check({tag, "_fcv"},   fc_valid_o,  0);
        check({tag, "_kind"},  fc_kind_o,   0);
        check({tag, "_class"}, fc_class_o,  0);
        check({tag, "_vc"},    fc_vc_o,     0);
        check({tag, "_hdr"},   hdr_fc_o,    0);
        check({tag, "_data"},  data_fc_o,   0);
        check({tag, "_gcnt"},  good_cnt_o,  0);
        check({tag, "_ecnt"},  err_cnt_o,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int m0, d0, c0;
        rst_i        = 1'b0;
        dllp_valid_i = 1'b0;
        dllp_sop_i   = 1'b0;
        dllp_data_i  = 8'h00;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        idle(2);

        // Ack seq 123, then the same with byte 4 bit 0 flipped.
        send_dllp(8'h00, 8'h00, 8'h01, 8'h23, 0, 0, mk(1, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h123));
        drain("drain_ack");
        send_dllp(8'h00, 8'h00, 8'h01, 8'h23, 1, 0, mk(0, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h123));
        drain("drain_bad_ack");

        // UpdateFC-NP VC0, without and with random gaps.
        send_dllp(8'h90, 8'h09, 8'h43, 8'hA7, 0, 0, mk(0, 0, 1, 2'd2, 2'd1, 3'd0, 8'h25, 12'h3A7, 12'h000));
        drain("drain_ufc");
        send_dllp(8'h90, 8'h09, 8'h43, 8'hA7, 0, 5, mk(0, 0, 1, 2'd2, 2'd1, 3'd0, 8'h25, 12'h3A7, 12'h000));
        drain("drain_ufc_gaps");

        // InitFC2-Cpl VC3, InitFC1-P VC7, FC type with bit 3 set, unknown type.
        send_dllp(8'hE3, 8'h3F, 8'hC1, 8'h22, 0, 0, mk(0, 0, 1, 2'd1, 2'd2, 3'd3, 8'hFF, 12'h122, 12'h000));
        send_dllp(8'h47, 8'h00, 8'h80, 8'h10, 0, 0, mk(0, 0, 1, 2'd0, 2'd0, 3'd7, 8'h02, 12'h010, 12'h000));
        send_dllp(8'h48, 8'h00, 8'h80, 8'h10, 0, 1, mk(0, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h000));
        send_dllp(8'h20, 8'h12, 8'h34, 8'h56, 0, 0, mk(0, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h000));
        drain("drain_fc_mix");

        // Stray byte while idle.
        m0 = mal_cnt;
        drive(8'h55, 1'b0);
        idle(2);
        check("idle_no_sop_malformed", mal_cnt - m0, 1);

        // Truncation by sop on byte 3, followed by a complete Nak.
        m0 = mal_cnt;
        d0 = done_cnt;
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b0);
        drive(8'h01, 1'b0);
        send_dllp(8'h10, 8'h00, 8'h0F, 8'hFF, 0, 0, mk(0, 1, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'hFFF));
        drain("drain_trunc_nak");
        check("trunc_malformed", mal_cnt - m0, 1);
        check("trunc_done_count", done_cnt - d0, 1);

        // Back-to-back with valid held high for 12 cycles.
        c0 = done_cyc.size();
        send_dllp(8'h00, 8'h00, 8'h00, 8'h01, 0, 0, mk(1, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h001));
        send_dllp(8'h00, 8'h00, 8'h00, 8'h02, 0, 0, mk(1, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h002));
        drain("drain_b2b");
        if (done_cyc.size() >= c0 + 2) begin
            check("b2b_spacing", done_cyc[c0 + 1] - done_cyc[c0], 6);
        end else begin
            total++;
            bad++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_cyc.size() - c0);
        end

        // Five bad DLLPs: error counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            send_dllp(8'h00, 8'h00, 8'h01, 8'h23, 1, 0, mk(0, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h000));
        end
        drain("drain_bad5");
        check("err_cnt_saturated", err_cnt_o, 2'd3);
        check("good_cnt_saturated", good_cnt_o, 2'd3);

        // Reset in the middle of a DLLP.
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b0);
        drive(8'h01, 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("midrst");
        @(posedge clk_i);
        #1;
        rst_i    = 1'b1;
        mdl_good = 0;
        mdl_err  = 0;
        idle(1);

        m0 = mal_cnt;
        send_dllp(8'h00, 8'h00, 8'h04, 8'h56, 0, 0, mk(1, 0, 0, 2'd0, 2'd0, 3'd0, 8'h00, 12'h000, 12'h456));
        drain("drain_post_reset");
        check("post_reset_no_malformed", mal_cnt - m0, 0);
        check("post_reset_good_cnt", good_cnt_o, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
